// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable top (MAX), parallel load,
// wrap/saturate boundary mode, combinational terminal count and carry/borrow pulses.
module updown_counter_param #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX       = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1),
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Down,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_val,
  input  logic             Sat,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Carry,
  output logic             Borrow
);

  // One extra bit so the clamp compare stays exact when MAX is the full range.
  localparam logic [WIDTH:0]   MAX_X = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH-1:0] MAX_V = MAX_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             at_max, at_zero;
  logic [WIDTH:0]   load_x;

  assign at_max  = (q_q == MAX_V);
  assign at_zero = (q_q == '0);
  assign load_x  = {1'b0, Load_val};

  always_comb begin
    q_d      = q_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (Load) begin
      q_d = (load_x > MAX_X) ? MAX_V : Load_val;
    end else if (En) begin
      if (!Down) begin
        if (!at_max) begin
          q_d = q_q + WIDTH'(1);
        end else if (!Sat) begin
          q_d     = '0;
          carry_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_d = q_q - WIDTH'(1);
        end else if (!Sat) begin
          q_d      = MAX_V;
          borrow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      q_q      <= RST_V;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  // Tc ignores Sat and Load so it can drive the next stage's En directly.
  assign Tc     = En & ((~Down & at_max) | (Down & at_zero));
  assign Q      = q_q;
  assign Carry  = carry_q;
  assign Borrow = borrow_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three parameterisations driven by shared controls,
// each compared against an arithmetic reference model.
module tb_updown_counter_param;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic       En = 1'b0, Down = 1'b0, Load = 1'b0, Sat = 1'b0;
  logic [3:0] lv = '0;

  logic [3:0] qa, qb;
  logic [1:0] qc;
  logic       tca, tcb, tcc, ca, cb, cc, ba, bb, bc;

  int unsigned passed = 0;
  int unsigned total  = 0;

  localparam int unsigned MX [3] = '{9, 15, 1};
  localparam int unsigned RV [3] = '{3, 0, 0};
  localparam int unsigned WD [3] = '{4, 4, 2};

  int unsigned mq [3];
  int unsigned mc [3];
  int unsigned mb [3];

  always #5 clock = ~clock;

  updown_counter_param #(.WIDTH(4), .MAX(9), .RESET_VAL(3)) u_a (
    .clock(clock), .Reset(Reset), .En(En), .Down(Down), .Load(Load), .Load_val(lv),
    .Sat(Sat), .Q(qa), .Tc(tca), .Carry(ca), .Borrow(ba));

  updown_counter_param #(.WIDTH(4), .MAX(15), .RESET_VAL(0)) u_b (
    .clock(clock), .Reset(Reset), .En(En), .Down(Down), .Load(Load), .Load_val(lv),
    .Sat(Sat), .Q(qb), .Tc(tcb), .Carry(cb), .Borrow(bb));

  updown_counter_param #(.WIDTH(2), .MAX(1), .RESET_VAL(0)) u_c (
    .clock(clock), .Reset(Reset), .En(En), .Down(Down), .Load(Load), .Load_val(lv[1:0]),
    .Sat(Sat), .Q(qc), .Tc(tcc), .Carry(cc), .Borrow(bc));

  function automatic logic [31:0] dut_q(int i);
    case (i)
      0:       return {28'd0, qa};
      1:       return {28'd0, qb};
      default: return {30'd0, qc};
    endcase
  endfunction

  function automatic logic dut_tc(int i);
    case (i)
      0: return tca; 1: return tcb; default: return tcc;
    endcase
  endfunction

  function automatic logic dut_c(int i);
    case (i)
      0: return ca; 1: return cb; default: return cc;
    endcase
  endfunction

  function automatic logic dut_b(int i);
    case (i)
      0: return ba; 1: return bb; default: return bc;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = RV[i]; mc[i] = 0; mb[i] = 0;
    end
  endfunction

  // Counting modulo MAX+1: a wrap is exactly when the modular result crosses the boundary.
  function automatic void model_edge(int i, bit en_, bit dn_, bit ld_, bit sat_, int unsigned lv_);
    int unsigned v, nq;
    v = lv_ % (1 << WD[i]);
    mc[i] = 0; mb[i] = 0;
    if (ld_) begin
      mq[i] = (v > MX[i]) ? MX[i] : v;
    end else if (en_) begin
      if (!dn_) begin
        if (sat_) mq[i] = (mq[i] + 1 > MX[i]) ? MX[i] : mq[i] + 1;
        else begin
          nq = (mq[i] + 1) % (MX[i] + 1);
          mc[i] = (nq < mq[i]) ? 1 : 0;
          mq[i] = nq;
        end
      end else begin
        if (sat_) mq[i] = (mq[i] == 0) ? 0 : mq[i] - 1;
        else begin
          nq = (mq[i] + MX[i]) % (MX[i] + 1);
          mb[i] = (nq > mq[i]) ? 1 : 0;
          mq[i] = nq;
        end
      end
    end
  endfunction

  function automatic logic model_tc(int i, bit en_, bit dn_);
    return en_ && ((!dn_ && mq[i] == MX[i]) || (dn_ && mq[i] == 0));
  endfunction

  task automatic chk(string tag, int inst, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, exp);
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".q"}, i, dut_q(i), mq[i]);
      chk({tag, ".carry"}, i, {31'd0, dut_c(i)}, mc[i]);
      chk({tag, ".borrow"}, i, {31'd0, dut_b(i)}, mb[i]);
    end
  endtask

  task automatic cycle(string tag, bit en_, bit dn_, bit ld_, bit sat_, logic [3:0] lv_);
    En = en_; Down = dn_; Load = ld_; Sat = sat_; lv = lv_;
    #1;
    for (int i = 0; i < 3; i++)
      chk({tag, ".tc"}, i, {31'd0, dut_tc(i)}, {31'd0, model_tc(i, en_, dn_)});
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_edge(i, en_, dn_, ld_, sat_, lv_);
    #1;
    check_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset held for three clocks with counting requested.
    En = 1'b1; Down = 1'b0;
    #2 Reset = 1'b0;
    model_reset();
    #1 check_all("rst_async");
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check_all("rst_hold");
    end
    @(negedge clock) Reset = 1'b1;
    cycle("rst_release", 1, 0, 0, 0, 4'd0);

    // Up wrap from zero, 12 edges.
    cycle("ld0", 1, 0, 1, 0, 4'd0);
    for (int k = 0; k < 12; k++) cycle("up_wrap", 1, 0, 0, 0, 4'd0);

    // Hold with En low.
    cycle("hold", 0, 1, 0, 0, 4'd0);

    // Down wrap, then saturate at zero.
    cycle("ld1", 0, 0, 1, 0, 4'd1);
    for (int k = 0; k < 3; k++) cycle("dn_wrap", 1, 1, 0, 0, 4'd0);
    cycle("ld0b", 0, 0, 1, 0, 4'd0);
    for (int k = 0; k < 3; k++) cycle("dn_sat", 1, 1, 0, 1, 4'd0);
    cycle("ld_top", 0, 0, 1, 0, 4'd15);
    for (int k = 0; k < 2; k++) cycle("up_sat", 1, 0, 0, 1, 4'd0);

    // Load beats En; out-of-range loads clamp.
    cycle("ld5", 0, 0, 1, 0, 4'd5);
    cycle("ld_pri", 1, 0, 1, 0, 4'd7);
    cycle("ld_clamp", 1, 1, 1, 0, 4'd14);

    // Full-range wrap then immediate reversal.
    cycle("ld15", 0, 0, 1, 0, 4'd15);
    cycle("full_up", 1, 0, 0, 0, 4'd0);
    cycle("full_rev", 1, 1, 0, 0, 4'd0);

    // Async reset half a period after a carry edge.
    cycle("ld9", 0, 0, 1, 0, 4'd9);
    cycle("pre_arst", 1, 0, 0, 0, 4'd0);
    #4 Reset = 1'b0;
    model_reset();
    #1 check_all("arst_mid");
    @(posedge clock); #1;
    check_all("arst_hold");
    @(negedge clock) Reset = 1'b1;

    // Randomised controls.
    for (int k = 0; k < 300; k++) begin
      cycle("rand",
            ($urandom_range(3, 0) != 0),
            1'($urandom_range(1, 0)),
            ($urandom_range(7, 0) == 0),
            ($urandom_range(3, 0) == 0),
            4'($urandom_range(15, 0)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
